// File: rtl/router_pkg.sv
// Shared router types: arbiter FSM states, packet-buffer states, index helper.
package router_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        STREAM,
        DRAIN,
        GAP
    } arb_state_t;

    // Packet-buffer side view, shared with the buffer blocks.
    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_FILL,
        BUF_READY,
        BUF_SEND
    } buf_state_t;

    localparam int CNT_W = 16;

    // (a + b) mod n for a, b already in [0, n).
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin picker: first asserted request at or after the pointer.
module rr_select
    import router_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_any,
    output logic [IW-1:0] o_idx
);

    logic w_found;

    // Scan N slots starting at the pointer, wrapping, keep the first hit.
    always_comb begin
        o_any   = |i_req;
        o_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && i_req[wrap_add(int'(i_ptr), k, N)]) begin
                w_found = 1'b1;
                o_idx   = IW'(wrap_add(int'(i_ptr), k, N));
            end
        end
    end

endmodule

// File: rtl/route_arbiter.sv
// Arbitrates N packet buffers onto one output: grant, stream or drop, count.
module route_arbiter
    import router_pkg::*;
#(
    parameter  int N_PORTS = 4,
    parameter  int LEN_W   = 8,
    parameter  int MAX_LEN = 64,
    parameter  int TIMEOUT = 255,
    localparam int IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
    localparam int STALL_W = $clog2(TIMEOUT + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_PORTS-1:0]       buf_control_ready,
    input  logic [N_PORTS-1:0]       buf_packet_ready,
    input  logic [N_PORTS*LEN_W-1:0] buf_packet_length,
    input  logic [N_PORTS-1:0]       buf_out_flit_valid,
    output logic [N_PORTS-1:0]       buf_control_valid,
    output logic [N_PORTS-1:0]       buf_stream,
    output logic [N_PORTS-1:0]       buf_drop,
    output logic                     grant_valid,
    output logic [IDX_W-1:0]         grant_idx,
    output logic [CNT_W-1:0]         n_streamed,
    output logic [CNT_W-1:0]         n_dropped,
    output logic                     timeout_err
);

    arb_state_t           r_state, w_next;
    logic [IDX_W-1:0]     r_sel, r_ptr;
    logic [LEN_W-1:0]     r_len, r_cnt;
    logic [STALL_W-1:0]   r_stall;
    logic [CNT_W-1:0]     r_n_streamed, r_n_dropped;
    logic                 r_timeout_err;

    logic [N_PORTS-1:0]   w_elig;
    logic                 w_any;
    logic [IDX_W-1:0]     w_pick;
    logic [LEN_W-1:0]     w_len_arr [N_PORTS];
    logic                 w_bad_len, w_strobe, w_last_flit, w_stall_hit, w_drain_done;

    assign w_elig = buf_packet_ready & buf_control_ready;

    rr_select #(.N(N_PORTS)) u_rr (
        .i_req (w_elig),
        .i_ptr (r_ptr),
        .o_any (w_any),
        .o_idx (w_pick)
    );

    // Unpack the flat per-port length bus.
    always_comb begin
        for (int i = 0; i < N_PORTS; i++)
            w_len_arr[i] = buf_packet_length[i*LEN_W +: LEN_W];
    end

    assign w_bad_len    = (r_len == '0) || (32'(r_len) > MAX_LEN);
    assign w_strobe     = buf_out_flit_valid[r_sel];
    assign w_last_flit  = w_strobe && ((r_cnt + LEN_W'(1)) == r_len);
    assign w_stall_hit  = !w_strobe && (r_stall == STALL_W'(TIMEOUT - 1));
    // Drain count starts at 1 in ISSUE, so a zero length still takes one cycle.
    assign w_drain_done = (r_cnt >= r_len);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = ISSUE;
            ISSUE:   w_next = w_bad_len ? DRAIN : STREAM;
            STREAM:  if (w_last_flit || w_stall_hit) w_next = GAP;
            DRAIN:   if (w_drain_done) w_next = GAP;
            GAP:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs: one command pulse in ISSUE, grant held through STREAM.
    always_comb begin
        buf_control_valid = '0;
        buf_stream        = '0;
        buf_drop          = '0;
        grant_valid       = (r_state == STREAM);
        grant_idx         = (r_state == STREAM) ? r_sel : '0;
        if (r_state == ISSUE) begin
            buf_control_valid[r_sel] = 1'b1;
            if (w_bad_len) buf_drop[r_sel]   = 1'b1;
            else           buf_stream[r_sel] = 1'b1;
        end
    end

    // Datapath: capture grant, count flits/drain/stall, update stats and pointer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sel         <= '0;
            r_ptr         <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_stall       <= '0;
            r_n_streamed  <= '0;
            r_n_dropped   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_sel <= w_pick;
                        r_len <= w_len_arr[w_pick];
                    end
                end
                ISSUE: begin
                    r_cnt   <= w_bad_len ? LEN_W'(1) : '0;
                    r_stall <= '0;
                end
                STREAM: begin
                    if (w_strobe) begin
                        r_cnt   <= r_cnt + LEN_W'(1);
                        r_stall <= '0;
                    end else begin
                        r_stall <= r_stall + STALL_W'(1);
                    end
                    if (w_last_flit && r_n_streamed != '1)
                        r_n_streamed <= r_n_streamed + CNT_W'(1);
                    if (w_stall_hit) begin
                        r_timeout_err <= 1'b1;
                        if (r_n_dropped != '1) r_n_dropped <= r_n_dropped + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (w_drain_done) begin
                        if (r_n_dropped != '1) r_n_dropped <= r_n_dropped + CNT_W'(1);
                    end else begin
                        r_cnt <= r_cnt + LEN_W'(1);
                    end
                end
                GAP: begin
                    r_ptr <= (r_sel == IDX_W'(N_PORTS - 1)) ? '0 : r_sel + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign n_streamed  = r_n_streamed;
    assign n_dropped   = r_n_dropped;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_route_arbiter.sv
// Scoreboarded bench for route_arbiter: expected commands queued at stimulus time.
module tb_route_arbiter;
    localparam int N  = 4;
    localparam int LW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    buf_control_ready  = '0;
    logic [N-1:0]    buf_packet_ready   = '0;
    logic [N*LW-1:0] buf_packet_length  = '0;
    logic [N-1:0]    buf_out_flit_valid = '0;
    logic [N-1:0]    buf_control_valid, buf_stream, buf_drop;
    logic            grant_valid;
    logic [1:0]      grant_idx;
    logic [15:0]     n_streamed, n_dropped;
    logic            timeout_err;

    route_arbiter #(.N_PORTS(N), .LEN_W(LW), .MAX_LEN(64), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .buf_control_ready(buf_control_ready),
        .buf_packet_ready(buf_packet_ready),
        .buf_packet_length(buf_packet_length),
        .buf_out_flit_valid(buf_out_flit_valid),
        .buf_control_valid(buf_control_valid),
        .buf_stream(buf_stream),
        .buf_drop(buf_drop),
        .grant_valid(grant_valid),
        .grant_idx(grant_idx),
        .n_streamed(n_streamed),
        .n_dropped(n_dropped),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct { int port; bit drop; } exp_t;
    exp_t sb[$];
    exp_t m_e;
    int   m_p;
    int   total = 0;
    int   bad   = 0;
    logic [15:0] exp_str = '0;
    logic [15:0] exp_drp = '0;

    // Monitor: command exclusivity every cycle, and each command pulse against the queue.
    always @(negedge clk) begin
        if (rst) begin
            total++;
            if ((buf_stream & buf_drop) != '0 || !$onehot0(buf_control_valid)) begin
                bad++;
                $display("FAIL cmd_excl valid=%b stream=%b drop=%b", buf_control_valid, buf_stream, buf_drop);
            end
            if (|buf_control_valid) begin
                m_p = -1;
                for (int k = 0; k < N; k++) if (buf_control_valid[k]) m_p = k;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_cmd port=%0d stream=%b drop=%b", m_p, buf_stream, buf_drop);
                end else begin
                    m_e = sb.pop_front();
                    if (m_p !== m_e.port || buf_drop[m_p] !== m_e.drop || buf_stream[m_p] !== !m_e.drop) begin
                        bad++;
                        $display("FAIL cmd port=%0d drop=%b stream=%b want port=%0d drop=%b",
                                 m_p, buf_drop[m_p], buf_stream[m_p], m_e.port, m_e.drop);
                    end
                end
            end
        end
    end

    task automatic wait_issue(input string nm);
        bit ok = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (|buf_control_valid) begin ok = 1; break; end
        end
        total++;
        if (!ok) begin bad++; $display("FAIL %s issue_timeout got none want a command pulse", nm); end
    endtask

    task automatic set_len(input int p, input int len);
        buf_packet_length[p*LW +: LW] = LW'(len);
    endtask

    task automatic apply_reset();
        rst = 0;
        buf_packet_ready = '0;
        buf_out_flit_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1;
        exp_str = '0;
        exp_drp = '0;
    endtask

    task automatic test_reset();
        buf_control_ready = '1;
        repeat (3) @(negedge clk);
        total++;
        if (grant_valid !== 1'b0 || grant_idx !== 2'd0) begin
            bad++; $display("FAIL rst_grant got %b/%0d want 0/0", grant_valid, grant_idx);
        end
        total++;
        if (buf_control_valid !== '0 || buf_stream !== '0 || buf_drop !== '0) begin
            bad++; $display("FAIL rst_buf got %b %b %b want 0", buf_control_valid, buf_stream, buf_drop);
        end
        total++;
        if (n_streamed !== 16'd0 || n_dropped !== 16'd0 || timeout_err !== 1'b0) begin
            bad++; $display("FAIL rst_cnt got %h %h %b want 0 0 0", n_streamed, n_dropped, timeout_err);
        end
        rst = 1;
    endtask

    task automatic test_round_robin();
        for (int p = 0; p < N; p++) set_len(p, 2);
        for (int g = 0; g < 5; g++) sb.push_back('{g % N, 1'b0});
        buf_packet_ready = '1;
        for (int g = 0; g < 5; g++) begin
            wait_issue("rr");
            if (g == 4) buf_packet_ready = '0;
            @(negedge clk);
            total++;
            if (grant_valid !== 1'b1 || grant_idx !== 2'(g % N)) begin
                bad++; $display("FAIL rr_order[%0d] got %b/%0d want 1/%0d", g, grant_valid, grant_idx, g % N);
            end
            for (int k = 0; k < 2; k++) begin
                buf_out_flit_valid[g % N] = 1'b1;
                @(negedge clk);
            end
            buf_out_flit_valid = '0;
            exp_str++;
        end
        @(negedge clk);
        total++;
        if (n_streamed !== exp_str) begin
            bad++; $display("FAIL rr_count got %0d want %0d", n_streamed, exp_str);
        end
    endtask

    task automatic test_single_stream();
        set_len(1, 4);
        sb.push_back('{1, 1'b0});
        buf_packet_ready[1] = 1'b1;
        wait_issue("single");
        buf_packet_ready[1] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (grant_valid !== 1'b1 || grant_idx !== 2'd1) begin
                bad++; $display("FAIL single_grant[%0d] got %b/%0d want 1/1", k, grant_valid, grant_idx);
            end
            buf_out_flit_valid[1] = 1'b1;
            @(negedge clk);
        end
        buf_out_flit_valid = '0;
        exp_str++;
        total++;
        if (grant_valid !== 1'b0) begin
            bad++; $display("FAIL single_gap got grant=%b want 0", grant_valid);
        end
        total++;
        if (n_streamed !== exp_str || n_dropped !== exp_drp) begin
            bad++; $display("FAIL single_count got %0d/%0d want %0d/%0d", n_streamed, n_dropped, exp_str, exp_drp);
        end
    endtask

    task automatic drop_one(input int len);
        logic [15:0] old;
        int c;
        bit granted;
        set_len(2, len);
        sb.push_back('{2, 1'b1});
        buf_packet_ready[2] = 1'b1;
        wait_issue("drop");
        buf_packet_ready[2] = 1'b0;
        old = n_dropped;
        c = 0;
        granted = 0;
        while (c < 200 && n_dropped === old) begin
            @(negedge clk);
            c++;
            if (grant_valid) granted = 1;
        end
        exp_drp++;
        total++;
        if (c !== ((len > 1) ? len : 1) + 1 || granted) begin
            bad++; $display("FAIL drop_len%0d cycles=%0d grant_seen=%b want cycles=%0d grant_seen=0",
                            len, c, granted, ((len > 1) ? len : 1) + 1);
        end
    endtask

    task automatic test_drop();
        drop_one(0);
        drop_one(65);
        @(negedge clk);
        total++;
        if (n_dropped !== exp_drp || n_streamed !== exp_str) begin
            bad++; $display("FAIL drop_count got %0d/%0d want %0d/%0d", n_dropped, n_streamed, exp_drp, exp_str);
        end
    endtask

    task automatic test_timeout();
        int c;
        set_len(0, 3);
        sb.push_back('{0, 1'b0});
        buf_packet_ready[0] = 1'b1;
        wait_issue("timeout");
        buf_packet_ready[0] = 1'b0;
        @(negedge clk);
        buf_out_flit_valid[0] = 1'b1;
        @(negedge clk);
        buf_out_flit_valid = '0;
        total++;
        if (timeout_err !== 1'b0) begin
            bad++; $display("FAIL timeout_early got %b want 0", timeout_err);
        end
        c = 0;
        while (c < 400 && timeout_err !== 1'b1) begin
            @(negedge clk);
            c++;
        end
        exp_drp++;
        total++;
        if (c !== 255 || grant_valid !== 1'b0) begin
            bad++; $display("FAIL timeout_cycles got %0d grant=%b want 255 grant=0", c, grant_valid);
        end
        @(negedge clk);
        total++;
        if (n_dropped !== exp_drp || n_streamed !== exp_str || dut.r_state !== router_pkg::IDLE) begin
            bad++; $display("FAIL timeout_count got %0d/%0d st=%0d want %0d/%0d IDLE",
                            n_dropped, n_streamed, dut.r_state, exp_drp, exp_str);
        end
    endtask

    task automatic test_reset_mid_stream();
        set_len(3, 4);
        sb.push_back('{3, 1'b0});
        buf_packet_ready[3] = 1'b1;
        wait_issue("rst_mid");
        buf_packet_ready[3] = 1'b0;
        @(negedge clk);
        buf_out_flit_valid[3] = 1'b1;
        @(negedge clk);
        buf_out_flit_valid = '0;
        rst = 0;
        @(negedge clk);
        total++;
        if (grant_valid !== 1'b0 || grant_idx !== 2'd0 || buf_control_valid !== '0 ||
            buf_stream !== '0 || buf_drop !== '0 || dut.r_state !== router_pkg::IDLE) begin
            bad++; $display("FAIL rst_mid_out got grant=%b idx=%0d st=%0d want 0 0 IDLE",
                            grant_valid, grant_idx, dut.r_state);
        end
        total++;
        if (n_streamed !== 16'd0 || n_dropped !== 16'd0 || timeout_err !== 1'b0) begin
            bad++; $display("FAIL rst_mid_cnt got %h %h %b want 0 0 0", n_streamed, n_dropped, timeout_err);
        end
        rst = 1;
        exp_str = '0;
        exp_drp = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic stream_len1();
        set_len(0, 1);
        sb.push_back('{0, 1'b0});
        buf_packet_ready[0] = 1'b1;
        wait_issue("sat");
        buf_packet_ready[0] = 1'b0;
        @(negedge clk);
        buf_out_flit_valid[0] = 1'b1;
        @(negedge clk);
        buf_out_flit_valid = '0;
    endtask

    task automatic test_saturation();
        force dut.r_n_streamed = 16'hFFFE;
        @(negedge clk);
        release dut.r_n_streamed;
        @(negedge clk);
        total++;
        if (n_streamed !== 16'hFFFE) begin
            bad++; $display("FAIL sat_preset got %h want FFFE", n_streamed);
        end
        stream_len1();
        total++;
        if (n_streamed !== 16'hFFFF) begin
            bad++; $display("FAIL sat_reach got %h want FFFF", n_streamed);
        end
        stream_len1();
        total++;
        if (n_streamed !== 16'hFFFF) begin
            bad++; $display("FAIL sat_hold got %h want FFFF", n_streamed);
        end
    endtask

    initial begin
        test_reset();
        apply_reset();
        test_round_robin();
        test_single_stream();
        test_drop();
        test_timeout();
        test_reset_mid_stream();
        test_saturation();
        repeat (3) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL sb_leftover got %0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
